// File: rtl/key_line_buffer.sv
// key_line_buffer: edited keyboard line buffer with show-ahead CPU pop port.
// Echo stream for the text display is built only when KBD_ECHO_EN is defined.
module key_line_buffer #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int KEY_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [7:0]    key_ascii,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_avail,
  output logic [AW:0]   line_count,
  output logic          overflow,
  output logic          echo_valid,
  output logic [7:0]    echo_char
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PROC
  } state_t;

  localparam logic [AW:0] ROOM_MAX = (AW+1)'(DEPTH - 3);
  localparam logic [1:0]  LAT_LD   = 2'(KEY_LAT - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_kv_q;
  logic [1:0]    r_cnt;
  logic [7:0]    r_char;
  logic [7:0]    r_buf [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_cm_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_line_cnt;
  logic          r_ovf;

  logic          w_event;
  logic          w_proc;
  logic          w_pop;
  logic          w_pop_nl;
  logic [AW-1:0] w_used;
  logic          w_room;
  logic [AW-1:0] w_wr_inc;
  logic          w_do_wr;
  logic          w_do_bs;
  logic          w_do_nl;
  logic          w_do_drop;

  assign w_event  = key_valid & ~r_kv_q;
  assign w_proc   = (r_state == S_PROC);
  assign rd_avail = (r_rd_ptr != r_cm_ptr);
  assign rd_data  = r_buf[r_rd_ptr];
  assign w_pop    = rd_en & rd_avail;
  assign w_pop_nl = w_pop & (rd_data == 8'h0A);
  // Room is judged on pre-edge pointers; one slot stays free for Enter.
  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign w_room   = ({1'b0, w_used} <= ROOM_MAX);
  assign w_wr_inc = r_wr_ptr + 1'b1;

  assign line_count = r_line_cnt;
  assign overflow   = r_ovf;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // FSM next state: key edge -> latency wait -> one processing cycle.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_event) w_state_nx = S_WAIT;
      S_WAIT: if (r_cnt == 2'd0) w_state_nx = S_PROC;
      S_PROC: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Edge register, latency counter and latched key code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kv_q <= 1'b0;
      r_cnt  <= 2'd0;
      r_char <= 8'h00;
    end else begin
      r_kv_q <= key_valid;
      if (r_state == S_IDLE && w_event)
        r_cnt <= LAT_LD;
      else if (r_state == S_WAIT && r_cnt != 2'd0)
        r_cnt <= r_cnt - 2'd1;
      if (r_state == S_WAIT && r_cnt == 2'd0)
        r_char <= key_ascii;
    end
  end

  // Classify the latched key during the processing cycle.
  always_comb begin
    w_do_wr   = 1'b0;
    w_do_bs   = 1'b0;
    w_do_nl   = 1'b0;
    w_do_drop = 1'b0;
    if (w_proc) begin
      unique case (1'b1)
        (r_char >= 8'h20 && r_char <= 8'h7E): begin
          w_do_wr   = w_room;
          w_do_drop = ~w_room;
        end
        (r_char == 8'h08):
          w_do_bs = (r_wr_ptr != r_cm_ptr);
        (r_char == 8'h0D || r_char == 8'h0A):
          w_do_nl = 1'b1;
        default: ;
      endcase
    end
  end

  // Character storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_do_wr)      r_buf[r_wr_ptr] <= r_char;
    else if (w_do_nl) r_buf[r_wr_ptr] <= 8'h0A;
  end

  // Pointers, line count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_line_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= w_wr_inc;
      if (w_do_bs) r_wr_ptr <= r_wr_ptr - 1'b1;
      if (w_do_nl) begin
        r_wr_ptr <= w_wr_inc;
        r_cm_ptr <= w_wr_inc;
      end
      if (w_do_drop) r_ovf <= 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_line_cnt <= r_line_cnt
                  + {{AW{1'b0}}, w_do_nl}
                  - {{AW{1'b0}}, w_pop_nl};
    end
  end

`ifdef KBD_ECHO_EN
  logic       r_echo_valid;
  logic [7:0] r_echo_char;
  logic       w_echo_en;

  assign w_echo_en  = w_do_wr | w_do_bs | w_do_nl;
  assign echo_valid = r_echo_valid;
  assign echo_char  = r_echo_char;

  // Echo strobe one cycle after processing; char held until next echo.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_valid <= 1'b0;
      r_echo_char  <= 8'h00;
    end else begin
      r_echo_valid <= w_echo_en;
      if (w_echo_en)
        r_echo_char <= w_do_bs ? 8'h08 :
                       w_do_nl ? 8'h0A : r_char;
    end
  end
`else
  assign echo_valid = 1'b0;
  assign echo_char  = 8'h00;
`endif

endmodule

// File: tb/tb_key_line_buffer.sv
// Scoreboard bench for key_line_buffer (DEPTH=8, KEY_LAT=2).
// Pops and echoes are checked by a monitor against queued expectations.
module tb_key_line_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_ascii = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_avail;
  logic [3:0] line_count;
  logic       overflow;
  logic       echo_valid;
  logic [7:0] echo_char;

  int vec  = 0;
  int errs = 0;
  logic [7:0] exp_rd[$];
  logic [7:0] exp_echo[$];

  key_line_buffer #(.DEPTH(8), .AW(3), .KEY_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ascii(key_ascii),
    .rd_en(rd_en), .rd_data(rd_data), .rd_avail(rd_avail),
    .line_count(line_count), .overflow(overflow),
    .echo_valid(echo_valid), .echo_char(echo_char)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [15:0] a, logic [15:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", n, a, e);
    end
  endfunction

  task automatic push_echo(input logic [7:0] b);
`ifdef KBD_ECHO_EN
    exp_echo.push_back(b);
`else
    if (b == 8'hFF) $display("unused echo %0h", b);
`endif
  endtask

  // Monitor: compare pops and echo strobes away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en && rd_avail) begin
        if (exp_rd.size() == 0) begin
          vec++; errs++;
          $display("FAIL rd_pop: got %0h, required no pop", rd_data);
        end else chk("rd_pop", rd_data, exp_rd.pop_front());
      end
      if (echo_valid) begin
        if (exp_echo.size() == 0) begin
          vec++; errs++;
          $display("FAIL echo: got %0h, required no echo", echo_char);
        end else chk("echo", echo_char, exp_echo.pop_front());
      end
    end
  end

  task automatic ke(input logic [7:0] c, input bit e, input logic [7:0] ev);
    if (e) push_echo(ev);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_ascii = c;
    repeat (4) @(posedge clk);
    #1 key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pop(input int n);
    @(posedge clk); #1;
    rd_en = 1'b1;
    repeat (n) @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_avail", rd_avail, 0);
    chk("rst_lines", line_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_echo_v", echo_valid, 0);
    chk("rst_echo_c", echo_char, 0);

    // "hi" Enter
    ke(8'h68, 1, 8'h68);
    ke(8'h69, 1, 8'h69);
    ke(8'h0D, 1, 8'h0A);
    chk("hi_lines", line_count, 1);
    chk("hi_avail", rd_avail, 1);
    exp_rd.push_back(8'h68);
    exp_rd.push_back(8'h69);
    exp_rd.push_back(8'h0A);
    pop(3);
    chk("hi_lines0", line_count, 0);
    chk("hi_avail0", rd_avail, 0);

    // "ab" BS "c" Enter
    ke(8'h61, 1, 8'h61);
    ke(8'h62, 1, 8'h62);
    ke(8'h08, 1, 8'h08);
    ke(8'h63, 1, 8'h63);
    ke(8'h0D, 1, 8'h0A);
    chk("bs_lines", line_count, 1);
    exp_rd.push_back(8'h61);
    exp_rd.push_back(8'h63);
    exp_rd.push_back(8'h0A);
    pop(3);
    chk("bs_avail0", rd_avail, 0);

    // Backspace with empty edit region; committed "x\n" pending (wraps)
    ke(8'h78, 1, 8'h78);
    ke(8'h0A, 1, 8'h0A);
    ke(8'h08, 0, 8'h00);
    ke(8'h00, 0, 8'h00);
    ke(8'h7F, 0, 8'h00);
    exp_rd.push_back(8'h78);
    exp_rd.push_back(8'h0A);
    pop(2);
    chk("x_lines0", line_count, 0);

    // Overflow: 10 printables, 6 fit in DEPTH=8
    for (int i = 0; i < 10; i++)
      ke(8'h30 + 8'(i), (i < 6), 8'h30 + 8'(i));
    chk("ovf_set", overflow, 1);
    ke(8'h0D, 1, 8'h0A);
    chk("ovf_lines", line_count, 1);
    for (int i = 0; i < 6; i++) exp_rd.push_back(8'h30 + 8'(i));
    exp_rd.push_back(8'h0A);
    pop(8);
    chk("ovf_avail0", rd_avail, 0);
    chk("ovf_lines0", line_count, 0);
    chk("ovf_q_empty", exp_rd.size(), 0);

    // Pop last newline in the same cycle the next line commits
    ke(8'h6B, 1, 8'h6B);
    ke(8'h0D, 1, 8'h0A);
    exp_rd.push_back(8'h6B);
    pop(1);
    ke(8'h6D, 1, 8'h6D);
    push_echo(8'h0A);
    exp_rd.push_back(8'h0A);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_ascii = 8'h0D;
    repeat (3) @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    key_valid = 1'b0;
    chk("sim_lines", line_count, 1);
    repeat (2) @(posedge clk);
    #1;
    exp_rd.push_back(8'h6D);
    exp_rd.push_back(8'h0A);
    pop(2);
    chk("sim_lines0", line_count, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-line with a committed line pending
    ke(8'h71, 1, 8'h71);
    ke(8'h0D, 1, 8'h0A);
    ke(8'h72, 1, 8'h72);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rr_avail", rd_avail, 0);
    chk("rr_lines", line_count, 0);
    chk("rr_ovf", overflow, 0);
    ke(8'h7A, 1, 8'h7A);
    ke(8'h0D, 1, 8'h0A);
    exp_rd.push_back(8'h7A);
    exp_rd.push_back(8'h0A);
    pop(2);
    chk("rr_lines0", line_count, 0);

    repeat (3) @(posedge clk);
    chk("end_rd_q", exp_rd.size(), 0);
    chk("end_echo_q", exp_echo.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
